// File: rtl/r5p_ls_mem.sv
// r5p_ls_mem: word-organized SRAM responder on the r5p load/store bus with LAT wait states.
// Define R5P_LS_MEM_ERR_EN to add ls_err (out-of-range and misaligned access reporting).
module r5p_ls_mem #(
  parameter int unsigned DAW  = 32,
  parameter int unsigned DDW  = 32,
  parameter int unsigned DSW  = DDW/8,
  parameter int unsigned SIZE = 4096,
  parameter int unsigned LAT  = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             ls_req,
  input  logic             ls_wen,
  input  logic [DAW-1:0]   ls_adr,
  input  logic [DSW-1:0]   ls_sel,
  input  logic [DSW*8-1:0] ls_wdt,
  output logic [DSW*8-1:0] ls_rdt,
  output logic             ls_ack
`ifdef R5P_LS_MEM_ERR_EN
  ,
  output logic             ls_err
`endif
);

  localparam int unsigned DWW   = $clog2(DSW);
  localparam int unsigned MAW   = $clog2(SIZE);
  localparam int unsigned WORDS = SIZE/DSW;
  localparam logic [DAW-1:0] HI_MASK = ~(DAW'(SIZE - 1));

  logic [DSW*8-1:0]   mem [0:WORDS-1];
  logic [MAW-DWW-1:0] idx_s;
  logic [DSW*8-1:0]   mem_rdt_s;
  logic               acc_err_s;
  logic               ack_s;
  logic               wr_s;

  assign idx_s     = ls_adr[MAW-1:DWW];
  assign mem_rdt_s = mem[idx_s];

`ifdef R5P_LS_MEM_ERR_EN
  // A legal select is one contiguous run of lanes starting at the addressed byte (or empty).
  function automatic logic sel_misaligned(input logic [DSW-1:0] sel, input logic [DWW-1:0] off);
    logic [DSW-1:0] shf;
    logic [DSW-1:0] low;
    shf = sel >> off;
    low = sel & ((DSW'(1) << off) - DSW'(1));
    return (|low) || (|(shf & (shf + DSW'(1))));
  endfunction

  assign acc_err_s = (|(ls_adr & HI_MASK)) | sel_misaligned(ls_sel, ls_adr[DWW-1:0]);
`else
  logic unused_s;
  assign acc_err_s = 1'b0;
  assign unused_s  = ^{ls_adr & HI_MASK, ls_adr[DWW-1:0]};
`endif

  assign wr_s = ack_s & ls_wen & ~acc_err_s;

  // byte-lane write at the edge ending the ack cycle; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_s) begin
      for (int i = 0; i < DSW; i++) begin
        if (ls_sel[i]) mem[idx_s][8*i +: 8] <= ls_wdt[8*i +: 8];
      end
    end
  end

  generate
    if (LAT == 0) begin : g_comb
      assign ack_s  = ls_req;
      assign ls_ack = ls_req;

      // combinational read path, forced to zero on an erroring access
      always_comb begin
        if (acc_err_s) begin
          ls_rdt = '0;
        end else begin
          ls_rdt = mem_rdt_s;
        end
      end

`ifdef R5P_LS_MEM_ERR_EN
      assign ls_err = ls_req & acc_err_s;
`endif
    end else begin : g_wait
      typedef enum logic {ST_IDLE, ST_WAIT} state_t;
      localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

      state_t           state_r;
      logic [3:0]       cnt_r;
      logic             ack_r;
      logic [DSW*8-1:0] rdt_r;
      logic             arm_s;
`ifdef R5P_LS_MEM_ERR_EN
      logic             err_r;
      assign ls_err = err_r;
`endif

      // arm_s: the coming edge enters the ack cycle
      assign arm_s  = ls_req & ~ack_r & (cnt_r == LAT_M1);
      assign ack_s  = ack_r & ls_req;
      assign ls_ack = ack_r;
      assign ls_rdt = rdt_r;

      // wait-state counter FSM with registered ack, read data and error
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          ack_r   <= 1'b0;
          rdt_r   <= '0;
`ifdef R5P_LS_MEM_ERR_EN
          err_r   <= 1'b0;
`endif
        end else begin
          ack_r <= arm_s;
`ifdef R5P_LS_MEM_ERR_EN
          err_r <= arm_s & acc_err_s;
`endif
          if (arm_s && !ls_wen) begin
            rdt_r <= acc_err_s ? '0 : mem_rdt_s;
          end
          case (state_r)
            ST_IDLE: begin
              if (ls_req) begin
                state_r <= ST_WAIT;
                cnt_r   <= 4'd1;
              end else begin
                cnt_r   <= 4'd0;
              end
            end
            ST_WAIT: begin
              // ack done or request abandoned: restart from zero
              if (ack_r || !ls_req) begin
                state_r <= ST_IDLE;
                cnt_r   <= 4'd0;
              end else begin
                cnt_r   <= cnt_r + 4'd1;
              end
            end
            default: begin
              state_r <= ST_IDLE;
              cnt_r   <= 4'd0;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_r5p_ls_mem.sv
// tb_r5p_ls_mem: scoreboard bench driving four r5p_ls_mem instances with LAT = 0..3.
module tb_r5p_ls_mem;

`ifdef R5P_LS_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [4];
  logic        wen [4];
  logic [31:0] adr [4];
  logic [3:0]  sel [4];
  logic [31:0] wdt [4];
  logic [31:0] rdt [4];
  logic        ack [4];
`ifdef R5P_LS_MEM_ERR_EN
  logic        err [4];
`endif

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] rdt;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  bit   [31:0] mdl [4][1024];
  logic [31:0] last_rdt [4];
  int          n_chk;
  int          n_fail;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    r5p_ls_mem #(.LAT(g)) dut (
      .clk    (clk),
      .rst    (rst),
      .ls_req (req[g]),
      .ls_wen (wen[g]),
      .ls_adr (adr[g]),
      .ls_sel (sel[g]),
      .ls_wdt (wdt[g]),
      .ls_rdt (rdt[g]),
      .ls_ack (ack[g])
`ifdef R5P_LS_MEM_ERR_EN
      ,
      .ls_err (err[g])
`endif
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a, input logic [3:0] s);
    bit ok;
    ok = (s == 4'b0000);
    for (int n = 1; n <= 4 - int'(a[1:0]); n++) begin
      if (s == 4'(((1 << n) - 1) << a[1:0])) ok = 1'b1;
    end
    return (a[31:12] != 20'd0) || !ok;
  endfunction

  task automatic push_exp(input int u, input bit w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    exp_t e;
    int   wi;
    wi    = int'(a[11:2]);
    e.rd  = !w;
    e.lat = u;
    e.err = ERR_EN && exp_err(a, s);
    e.rdt = e.err ? 32'h0 : mdl[u][wi];
    if (w && !e.err) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) mdl[u][wi][8*i +: 8] = d[8*i +: 8];
      end
    end
    sb.push_back(e);
  endtask

  task automatic drive(input int u, input bit w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    @(posedge clk); #1;
    req[u] = 1'b1; wen[u] = w; adr[u] = a; sel[u] = s; wdt[u] = d;
  endtask

  task automatic wait_ack(input int u, input int base);
    exp_t e;
    int   n;
    bit   got;
    n   = base;
    got = 1'b0;
    while (!got && n < TMO) begin
      @(negedge clk);
      if (ack[u] === 1'b1) got = 1'b1;
      else n++;
    end
    e = sb.pop_front();
    check($sformatf("lat%0d_ack_cycle", u), n, e.lat);
    if (e.rd) begin
      check($sformatf("lat%0d_rdt", u), rdt[u], e.rdt);
      last_rdt[u] = e.rdt;
    end
`ifdef R5P_LS_MEM_ERR_EN
    check($sformatf("lat%0d_err", u), 32'(err[u]), 32'(e.err));
`endif
  endtask

  task automatic xfer(input int u, input bit w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    push_exp(u, w, a, s, d);
    drive(u, w, a, s, d);
    wait_ack(u, 0);
  endtask

  task automatic idle(input int u);
    @(posedge clk); #1;
    req[u] = 1'b0;
    wen[u] = 1'b0;
  endtask

  // write request withdrawn after ncyc cycles: never acked, nothing written
  task automatic abort(input int u, input logic [31:0] a, input logic [31:0] d, input int ncyc);
    drive(u, 1'b1, a, 4'hF, d);
    repeat (ncyc) begin
      @(negedge clk);
      check("abort_no_ack", 32'(ack[u]), 32'h0);
    end
    idle(u);
    @(negedge clk);
    check("abort_idle_ack", 32'(ack[u]), 32'h0);
    if (u != 0) check("abort_rdt_hold", rdt[u], last_rdt[u]);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int u = 0; u < 4; u++) begin
      req[u] = 1'b0; wen[u] = 1'b0; adr[u] = 32'h0; sel[u] = 4'h0; wdt[u] = 32'h0;
      last_rdt[u] = 32'h0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int u = 0; u < 4; u++) check($sformatf("reset_ack%0d", u), 32'(ack[u]), 32'h0);
    for (int u = 1; u < 4; u++) check($sformatf("reset_rdt%0d", u), rdt[u], 32'h0);

    // LAT=1: full write/read, empty-select write, aliasing / error cases
    xfer(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xfer(1, 1'b0, 32'h10, 4'hF, 32'h0);
    xfer(1, 1'b1, 32'h10, 4'h0, 32'h12345678);
    xfer(1, 1'b0, 32'h10, 4'hF, 32'h0);
    xfer(1, 1'b1, 32'h004, 4'hF, 32'h0BADC0DE);
    xfer(1, 1'b1, 32'h1004, 4'hF, 32'hCAFEF00D);
    xfer(1, 1'b0, 32'h004, 4'hF, 32'h0);
`ifdef R5P_LS_MEM_ERR_EN
    xfer(1, 1'b0, 32'h2, 4'hF, 32'h0);
    xfer(1, 1'b0, 32'h4, 4'hF, 32'h0);
`endif
    idle(1);

    // LAT=2: byte-lane merge, back-to-back with req held
    xfer(2, 1'b1, 32'h20, 4'hF, 32'h11223344);
    xfer(2, 1'b1, 32'h20, 4'b0100, 32'h00AA0000);
    xfer(2, 1'b0, 32'h20, 4'hF, 32'h0);
    idle(2);

    // LAT=0: req held four cycles, alternating write/read
    xfer(0, 1'b1, 32'h8, 4'hF, 32'h1);
    xfer(0, 1'b0, 32'h8, 4'hF, 32'h0);
    xfer(0, 1'b1, 32'h8, 4'hF, 32'h2);
    xfer(0, 1'b0, 32'h8, 4'hF, 32'h0);
    idle(0);

    // LAT=3: abandoned write, then reset in the middle of a wait
    xfer(3, 1'b1, 32'h30, 4'hF, 32'h55);
    xfer(3, 1'b0, 32'h30, 4'hF, 32'h0);
    idle(3);
    abort(3, 32'h30, 32'h99, 2);
    xfer(3, 1'b0, 32'h30, 4'hF, 32'h0);
    idle(3);

    push_exp(3, 1'b0, 32'h30, 4'hF, 32'h0);
    drive(3, 1'b0, 32'h30, 4'hF, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midwait_reset_ack", 32'(ack[3]), 32'h0);
    check("midwait_reset_rdt", rdt[3], 32'h0);
    for (int u = 0; u < 4; u++) last_rdt[u] = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    wait_ack(3, 1);
    idle(3);

    // memory of other instances survives the reset
    xfer(2, 1'b0, 32'h20, 4'hF, 32'h0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
